// File: rtl/i2c_register_bank.sv
// i2c_register_bank: byte-addressed register file behind an I2C slave front-end.
// The first byte of a write transaction loads the register pointer, later bytes
// write registers; read transactions stream registers out from the pointer.
// A host port gives local read/write access to the same registers.
// Optional feature macro: I2C_REGBANK_AUTOINC_EN (pointer advances after every
// WRITE/READ transfer). Without it, repeated bytes hit the same register.
//
// Handshakes: a byte moves on wr_valid && wr_ready (wr_ready is always 1 once
// out of reset) and on rd_valid && rd_ready; rd_data stays stable while
// rd_valid is high, and a new read is requested by rd_ready while !rd_valid.
module i2c_register_bank #(
  parameter int ADDR_WIDTH = 4,
  parameter int RO_BASE    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_start,
  input  logic                  i2c_stop,
  input  logic                  i2c_read,
  input  logic                  i2c_write,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic [7:0]            host_rdata,
  input  logic                  host_we,
  input  logic [7:0]            host_wdata,
  output logic                  reg_update,
  output logic [ADDR_WIDTH-1:0] reg_update_addr,
  output logic [2:0]            state_dbg
);

  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDRESSED = 3'd1,
    S_POINTER   = 3'd2,
    S_WRITE     = 3'd3,
    S_READ      = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [7:0]            regs [NREG];
  logic [ADDR_WIDTH-1:0] pointer, pointer_next;
  logic                  wr_xfer, rd_xfer, rd_abort, ro_hit, host_clash, i2c_commit;

  assign state_dbg = state;

  // Transfer qualifiers and the decision whether an I2C data byte is committed.
  always_comb begin
    wr_xfer    = wr_valid && wr_ready;
    rd_xfer    = rd_valid && rd_ready;
    rd_abort   = i2c_start || i2c_stop;
    ro_hit     = (int'(pointer) >= RO_BASE);
    host_clash = host_we && (host_addr == pointer);
    i2c_commit = (state == S_WRITE) && wr_xfer && !ro_hit && !host_clash;
  end

  // Next state: the byte is handled in the current state, start/stop override last.
  always_comb begin
    state_next = state;
    case (state)
      S_ADDRESSED: begin
        if (i2c_write)     state_next = S_POINTER;
        else if (i2c_read) state_next = S_READ;
      end
      S_POINTER: if (wr_xfer) state_next = S_WRITE;
      default: ;
    endcase
    if (i2c_start) state_next = S_ADDRESSED;
    if (i2c_stop)  state_next = S_IDLE;
  end

  // Pointer load in POINTER; optional advance after each WRITE/READ transfer.
  always_comb begin
    pointer_next = pointer;
    if ((state == S_POINTER) && wr_xfer) begin
      pointer_next = wr_data[ADDR_WIDTH-1:0];
    end
`ifdef I2C_REGBANK_AUTOINC_EN
    else if (((state == S_WRITE) && wr_xfer) ||
             ((state == S_READ) && rd_xfer && !rd_abort)) begin
      pointer_next = pointer + 1'b1;
    end
`else
    else begin
      pointer_next = pointer;
    end
`endif
  end

  // State and pointer registers; the pointer survives STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pointer <= '0;
    end else begin
      state   <= state_next;
      pointer <= pointer_next;
    end
  end

  // Register array: host write wins over a colliding I2C write to the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else begin
      if (i2c_commit) regs[pointer] <= wr_data;
      if (host_we)    regs[host_addr] <= host_wdata;
    end
  end

  // Output side: byte acceptance, read data path, commit pulse and host readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ready        <= 1'b0;
      rd_valid        <= 1'b0;
      rd_data         <= 8'h00;
      reg_update      <= 1'b0;
      reg_update_addr <= '0;
      host_rdata      <= 8'h00;
    end else begin
      wr_ready   <= 1'b1;
      reg_update <= i2c_commit;
      host_rdata <= regs[host_addr];
      if (i2c_commit) reg_update_addr <= pointer;
      if (rd_abort || rd_xfer) begin
        rd_valid <= 1'b0;
      end else if ((state == S_READ) && rd_ready && !rd_valid) begin
        rd_valid <= 1'b1;
        rd_data  <= regs[pointer];
      end
    end
  end

endmodule

// File: tb/tb_i2c_register_bank.sv
// Bench for i2c_register_bank: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the register bank.
module tb_i2c_register_bank;

  localparam int AW      = 4;
  localparam int NREG    = 1 << AW;
  localparam int RO_BASE = 12;
`ifdef I2C_REGBANK_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i2c_start = 0, i2c_stop = 0, i2c_read = 0, i2c_write = 0;
  logic          wr_valid = 0;
  logic [7:0]    wr_data = 0;
  logic          wr_ready;
  logic          rd_ready = 0;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [AW-1:0] host_addr = 0;
  logic [7:0]    host_rdata;
  logic          host_we = 0;
  logic [7:0]    host_wdata = 0;
  logic          reg_update;
  logic [AW-1:0] reg_update_addr;
  logic [2:0]    state_dbg;

  i2c_register_bank #(.ADDR_WIDTH(AW), .RO_BASE(RO_BASE)) dut (
    .clk(clk), .rst(rst),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_read(i2c_read), .i2c_write(i2c_write),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .host_addr(host_addr), .host_rdata(host_rdata), .host_we(host_we), .host_wdata(host_wdata),
    .reg_update(reg_update), .reg_update_addr(reg_update_addr), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state and reference model
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_q[$];
  logic [7:0]    tx_q[$];
  logic [7:0]    m_regs [NREG];
  int            m_ptr;
  int            n_checks = 0;
  int            n_errors = 0;

  // Collect every committed-write pulse the DUT produces
  always @(negedge clk) begin
    if (reg_update === 1'b1) mon_q.push_back(reg_update_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    mon_q.delete();
  endtask

  task automatic pulse_start();
    i2c_start = 1'b1; @(negedge clk); i2c_start = 1'b0;
  endtask

  task automatic pulse_stop();
    i2c_stop = 1'b1; @(negedge clk); i2c_stop = 1'b0;
    @(negedge clk);
  endtask

  // Write transaction with bytes from tx_q: first byte is the pointer
  task automatic write_txn();
    pulse_start();
    i2c_write = 1'b1; @(negedge clk); i2c_write = 1'b0;
    for (int k = 0; k < tx_q.size(); k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("wr_ready", wr_ready, 1);
      wr_valid = 1'b1; wr_data = tx_q[k];
      @(negedge clk);
      wr_valid = 1'b0;
      if (k == 0) begin
        m_ptr = tx_q[k] % NREG;
      end else begin
        if (m_ptr < RO_BASE) begin
          m_regs[m_ptr] = tx_q[k];
          exp_q.push_back(m_ptr[AW-1:0]);
        end
        if (AUTOINC) m_ptr = (m_ptr + 1) % NREG;
      end
    end
    pulse_stop();
  endtask

  task automatic check_updates();
    check("upd_count", mon_q.size(), exp_q.size());
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      check("upd_addr", mon_q.pop_front(), exp_q.pop_front());
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  // One read byte: request, bounded wait for valid, optional stall, accept
  task automatic read_byte();
    int lat;
    int hold;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rd_ready = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rd_valid !== 1'b1 && lat < 4);
    check("rd_latency", lat, 1);
    check("rd_data", rd_data, m_regs[m_ptr]);
    hold = $urandom_range(0, 2);
    if (hold > 0) begin
      rd_ready = 1'b0;
      repeat (hold) @(negedge clk);
      check("rd_hold_valid", rd_valid, 1);
      check("rd_hold_data", rd_data, m_regs[m_ptr]);
      rd_ready = 1'b1;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    check("rd_drop", rd_valid, 0);
    if (AUTOINC) m_ptr = (m_ptr + 1) % NREG;
  endtask

  task automatic read_txn(input int n);
    pulse_start();
    i2c_read = 1'b1; @(negedge clk); i2c_read = 1'b0;
    for (int k = 0; k < n; k++) read_byte();
    pulse_stop();
  endtask

  task automatic host_write(input int idx, input logic [7:0] data);
    host_we = 1'b1; host_addr = idx[AW-1:0]; host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
    m_regs[idx] = data;
  endtask

  task automatic host_read(input int idx, input string tag);
    host_addr = idx[AW-1:0];
    @(negedge clk);
    check(tag, host_rdata, m_regs[idx]);
  endtask

  initial begin
    model_reset();
    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_reg_update", reg_update, 0);
    check("rst_upd_addr", reg_update_addr, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);
    check("wr_ready_after_rst", wr_ready, 1);

    // Write 03,AA,BB then read back
    tx_q = '{8'h03, 8'hAA, 8'hBB};
    write_txn(); check_updates();
    host_read(3, "t1_reg3"); host_read(4, "t1_reg4");
    read_txn(1);

    // Pointer 0F: read-only drop, then wrap to reg0 when auto-incrementing
    tx_q = '{8'h0F, 8'h11, 8'h22};
    write_txn(); check_updates();
    host_read(15, "t2_reg15"); host_read(0, "t2_reg0");

    // Pointer-only write survives STOP; read three bytes
    host_write(2, 8'h21); host_write(3, 8'h31); host_write(4, 8'h41);
    tx_q = '{8'h02};
    write_txn(); check_updates();
    read_txn(3);

    // Repeated data bytes at pointer 5 (upper pointer bits ignored)
    tx_q = '{8'hF5, 8'h01, 8'h02, 8'h03};
    write_txn(); check_updates();
    host_read(5, "t4_reg5"); host_read(6, "t4_reg6");

    // Host write and I2C write to index 7 in the same cycle
    pulse_start();
    i2c_write = 1'b1; @(negedge clk); i2c_write = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h07; @(negedge clk);
    m_ptr = 7;
    wr_data = 8'h33; host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h5A;
    @(negedge clk);
    wr_valid = 1'b0; host_we = 1'b0;
    m_regs[7] = 8'h5A;
    if (AUTOINC) m_ptr = 8;
    pulse_stop(); check_updates();
    host_read(7, "t5_reg7");

    // STOP while rd_valid is high: valid clears, pointer stays
    tx_q = '{8'h09};
    write_txn(); check_updates();
    host_write(9, 8'h9C);
    pulse_start();
    i2c_read = 1'b1; @(negedge clk); i2c_read = 1'b0;
    rd_ready = 1'b1; @(negedge clk); rd_ready = 1'b0;
    check("stop_pre_valid", rd_valid, 1);
    i2c_stop = 1'b1; @(negedge clk); i2c_stop = 1'b0;
    check("stop_clears_valid", rd_valid, 0);
    read_txn(1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          tx_q.delete();
          tx_q.push_back(8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom_range(0, 255)));
          write_txn(); check_updates();
        end
        1: read_txn($urandom_range(1, 3));
        2: host_write($urandom_range(0, NREG - 1), 8'($urandom_range(0, 255)));
        default: begin
          tx_q = '{8'($urandom_range(0, 255))};
          write_txn(); check_updates();
          read_txn($urandom_range(1, 2));
        end
      endcase
    end
    for (int i = 0; i < NREG; i++) host_read(i, "rand_final_reg");

    // Reset in WRITE after the pointer byte, with a data byte in flight
    pulse_start();
    i2c_write = 1'b1; @(negedge clk); i2c_write = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h02; @(negedge clk);
    wr_data = 8'h77; rst = 1'b1; @(negedge clk);
    wr_valid = 1'b0; @(negedge clk);
    rst = 1'b0;
    model_reset(); mon_q.delete();
    check("t6_state", state_dbg, 0);
    check("t6_reg_update", reg_update, 0);
    wr_valid = 1'b1; wr_data = 8'h01; @(negedge clk);
    wr_data = 8'h55; @(negedge clk);
    wr_valid = 1'b0; @(negedge clk);
    check("t6_state_after", state_dbg, 0);
    check_updates();
    for (int i = 0; i < NREG; i++) host_read(i, "t6_reg");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
